openofdm_rx_ctrl: RTL and testbench

// Sequencer/watchdog for the openofdm_rx demodulator core. Watches the core's decode status

---
 rtl/openofdm_rx_ctrl_pkg.sv | 23 ++
 rtl/openofdm_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_openofdm_rx_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/openofdm_rx_ctrl_pkg.sv
// Shared encodings for the openofdm_rx sequencer/watchdog.
// State and abort-cause codes are visible on the status register, so their values are fixed.
package openofdm_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DEMOD   = 2'd1,
      ST_RESET   = 2'd2,
      ST_HOLDOFF = 2'd3
   } ctrl_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_TX      = 2'd1,
      CAUSE_HT      = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } cause_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/openofdm_rx_ctrl.sv
// Sequencer/watchdog beside openofdm_rx: aborts stalled or unsupported decodes, suppresses
// self-reception during TX and re-arms RX after a programmable hold-off.
module openofdm_rx_ctrl
   import openofdm_rx_ctrl_pkg::*;
#(
   parameter int TIMEOUT_WIDTH = 20,
   parameter int HOLDOFF_WIDTH = 16,
   parameter int RST_PULSE_LEN = 8,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     i_s00_axi_aclk,
   input  logic                     i_s00_axi_aresetn,
   input  logic                     i_cfg_watchdog_en,
   input  logic [TIMEOUT_WIDTH-1:0] i_cfg_demod_timeout,
   input  logic [HOLDOFF_WIDTH-1:0] i_cfg_tx_holdoff,
   input  logic                     i_tx_is_ongoing,
   input  logic                     i_demod_is_ongoing,
   input  logic                     i_pkt_header_valid_strobe,
   input  logic                     i_byte_out_strobe,
   input  logic                     i_ht_unsupport,
   input  logic                     i_fcs_out_strobe,
   output logic                     o_core_rst,
   output logic                     o_core_enable,
   output logic [1:0]               o_ctrl_state,
   output logic [1:0]               o_last_cause,
   output logic [CNT_WIDTH-1:0]     o_abort_cnt,
   output logic [CNT_WIDTH-1:0]     o_timeout_cnt
);

   localparam int TMR_W = max2(TIMEOUT_WIDTH, HOLDOFF_WIDTH);
   localparam logic [TMR_W-1:0] TMR_MAX  = '1;
   localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_PULSE_LEN - 1);

   ctrl_state_t            r_state;
   logic [TMR_W-1:0]       r_timer;
   logic                   r_core_rst;
   logic                   r_core_enable;
   cause_t                 r_last_cause;
   logic [CNT_WIDTH-1:0]   r_abort_cnt;
   logic [CNT_WIDTH-1:0]   r_timeout_cnt;

   ctrl_state_t            w_next_state;
   logic [TMR_W-1:0]       w_timer_next;
   logic                   w_enter_reset;
   logic                   w_timeout_abort;
   cause_t                 w_cause;
   logic                   w_expired;
   logic                   w_progress;

   // Expiry uses the pre-clear timer, so progress on the expiry clock cannot rescue the decode.
   assign w_expired  = i_cfg_watchdog_en && (i_cfg_demod_timeout != '0) &&
                       (r_timer >= TMR_W'(i_cfg_demod_timeout));
   assign w_progress = i_byte_out_strobe || i_pkt_header_valid_strobe;

   always_comb begin
      w_next_state    = r_state;
      w_timer_next    = r_timer;
      w_enter_reset   = 1'b0;
      w_timeout_abort = 1'b0;
      w_cause         = CAUSE_NONE;
      case (r_state)
         ST_IDLE: begin
            if (i_tx_is_ongoing) begin
               w_enter_reset = 1'b1;
               w_cause       = CAUSE_TX;
            end else if (i_demod_is_ongoing) begin
               w_next_state = ST_DEMOD;
               w_timer_next = '0;
            end
         end
         ST_DEMOD: begin
            if (i_tx_is_ongoing) begin
               w_enter_reset = 1'b1;
               w_cause       = CAUSE_TX;
            end else if (i_fcs_out_strobe || !i_demod_is_ongoing) begin
               w_next_state = ST_IDLE;
               w_timer_next = '0;
            end else if (i_ht_unsupport) begin
               w_enter_reset = 1'b1;
               w_cause       = CAUSE_HT;
            end else if (w_expired) begin
               w_enter_reset   = 1'b1;
               w_timeout_abort = 1'b1;
               w_cause         = CAUSE_TIMEOUT;
            end else if (w_progress) begin
               w_timer_next = '0;
            end else if (r_timer != TMR_MAX) begin
               w_timer_next = r_timer + 1'b1;
            end
         end
         ST_RESET: begin
            if (r_timer >= RST_LAST) begin
               w_next_state = ST_HOLDOFF;
               w_timer_next = '0;
            end else begin
               w_timer_next = r_timer + 1'b1;
            end
         end
         default: begin
            if (i_tx_is_ongoing) begin
               w_timer_next = '0;
            end else if (r_timer >= TMR_W'(i_cfg_tx_holdoff)) begin
               w_next_state = ST_IDLE;
               w_timer_next = '0;
            end else begin
               w_timer_next = r_timer + 1'b1;
            end
         end
      endcase
      if (w_enter_reset) begin
         w_next_state = ST_RESET;
         w_timer_next = '0;
      end
   end

   always_ff @(posedge i_s00_axi_aclk or negedge i_s00_axi_aresetn) begin
      if (!i_s00_axi_aresetn) begin
         r_state       <= ST_IDLE;
         r_timer       <= '0;
         r_core_rst    <= 1'b0;
         r_core_enable <= 1'b1;
         r_last_cause  <= CAUSE_NONE;
         r_abort_cnt   <= '0;
         r_timeout_cnt <= '0;
      end else begin
         r_state       <= w_next_state;
         r_timer       <= w_timer_next;
         r_core_rst    <= (w_next_state == ST_RESET);
         r_core_enable <= (w_next_state == ST_IDLE) || (w_next_state == ST_DEMOD);
         if (w_enter_reset) begin
            r_last_cause <= w_cause;
            if (r_abort_cnt != '1) r_abort_cnt <= r_abort_cnt + 1'b1;
         end
         if (w_timeout_abort && (r_timeout_cnt != '1)) begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
         end
      end
   end

   assign o_core_rst    = r_core_rst;
   assign o_core_enable = r_core_enable;
   assign o_ctrl_state  = r_state;
   assign o_last_cause  = r_last_cause;
   assign o_abort_cnt   = r_abort_cnt;
   assign o_timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_openofdm_rx_ctrl.sv
// Bench for openofdm_rx_ctrl: directed scenarios plus random traffic, all outputs compared
// every cycle against a countdown-style behavioural model.
module tb_openofdm_rx_ctrl;

   localparam int TB_CNT_W = 5;
   localparam int CMAX     = (1 << TB_CNT_W) - 1;
   localparam int TMAX     = (1 << 20) - 1;
   localparam int RST_LEN  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en, tx, demod, hdr, bytes, ht, fcs;
   logic [19:0] tmo_cfg;
   logic [15:0] hold_cfg;
   logic        o_core_rst, o_core_enable;
   logic [1:0]  o_ctrl_state, o_last_cause;
   logic [TB_CNT_W-1:0] o_abort_cnt, o_timeout_cnt;

   int n_err = 0;
   int n_chk = 0;
   bit cmp_en = 1'b0;

   // model: state, cause, counters, stall length, reset countdown, hold-off elapsed
   int m_state, m_cause, m_abort, m_tmo, m_stall, m_rst_left, m_hold;

   openofdm_rx_ctrl #(
      .TIMEOUT_WIDTH(20), .HOLDOFF_WIDTH(16), .RST_PULSE_LEN(RST_LEN), .CNT_WIDTH(TB_CNT_W)
   ) dut (
      .i_s00_axi_aclk(clk),
      .i_s00_axi_aresetn(rst_n),
      .i_cfg_watchdog_en(en),
      .i_cfg_demod_timeout(tmo_cfg),
      .i_cfg_tx_holdoff(hold_cfg),
      .i_tx_is_ongoing(tx),
      .i_demod_is_ongoing(demod),
      .i_pkt_header_valid_strobe(hdr),
      .i_byte_out_strobe(bytes),
      .i_ht_unsupport(ht),
      .i_fcs_out_strobe(fcs),
      .o_core_rst(o_core_rst),
      .o_core_enable(o_core_enable),
      .o_ctrl_state(o_ctrl_state),
      .o_last_cause(o_last_cause),
      .o_abort_cnt(o_abort_cnt),
      .o_timeout_cnt(o_timeout_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cause = 0; m_abort = 0; m_tmo = 0;
      m_stall = 0; m_rst_left = 0; m_hold = 0;
   endtask

   task automatic model_abort(input int cause);
      m_state    = 2;
      m_cause    = cause;
      m_rst_left = RST_LEN;
      m_abort    = (m_abort < CMAX) ? m_abort + 1 : CMAX;
   endtask

   task automatic model_step();
      case (m_state)
         0: begin
            if (tx) model_abort(1);
            else if (demod) begin m_state = 1; m_stall = 0; end
         end
         1: begin
            if (tx) model_abort(1);
            else if (fcs || !demod) m_state = 0;
            else if (ht) model_abort(2);
            else if (en && tmo_cfg != 0 && m_stall >= int'(tmo_cfg)) begin
               model_abort(3);
               m_tmo = (m_tmo < CMAX) ? m_tmo + 1 : CMAX;
            end
            else if (bytes || hdr) m_stall = 0;
            else if (m_stall < TMAX) m_stall++;
         end
         2: begin
            m_rst_left--;
            if (m_rst_left == 0) begin m_state = 3; m_hold = 0; end
         end
         default: begin
            if (tx) m_hold = 0;
            else if (m_hold >= int'(hold_cfg)) m_state = 0;
            else m_hold++;
         end
      endcase
   endtask

   // Inputs change on the falling edge; model advances on the rising edge it was sampled at.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic wait_state(input int target, input int limit, input string name);
      int n = 0;
      while (int'(o_ctrl_state) != target && n < limit) begin
         tick();
         n++;
      end
      chk(name, int'(o_ctrl_state), target);
   endtask

   task automatic async_reset_check(input string name);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk({name, "_state"}, int'(o_ctrl_state), 0);
      chk({name, "_core_rst"}, int'(o_core_rst), 0);
      chk({name, "_core_en"}, int'(o_core_enable), 1);
      chk({name, "_cause"}, int'(o_last_cause), 0);
      chk({name, "_abort"}, int'(o_abort_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_state", int'(o_ctrl_state), m_state);
         chk("cyc_core_rst", int'(o_core_rst), (m_state == 2) ? 1 : 0);
         chk("cyc_core_en", int'(o_core_enable), (m_state < 2) ? 1 : 0);
         chk("cyc_cause", int'(o_last_cause), m_cause);
         chk("cyc_abort", int'(o_abort_cnt), m_abort);
         chk("cyc_tmo", int'(o_timeout_cnt), m_tmo);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int n, hc, a0, t0;
      bit saw_rst, saw_demod;
      en = 1'b1; tx = 1'b0; demod = 1'b0; hdr = 1'b0; bytes = 1'b0; ht = 1'b0; fcs = 1'b0;
      tmo_cfg = 20'd100; hold_cfg = 16'd20;
      model_reset();
      #12;
      chk("rst_state", int'(o_ctrl_state), 0);
      chk("rst_core_rst", int'(o_core_rst), 0);
      chk("rst_core_en", int'(o_core_enable), 1);
      chk("rst_counters", int'(o_abort_cnt) + int'(o_timeout_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      repeat (3) tick();

      // normal packet
      saw_rst = 0; saw_demod = 0;
      demod = 1'b1;
      for (int i = 0; i < 200; i++) begin
         bytes = (i % 50 == 25);
         tick();
         if (o_core_rst) saw_rst = 1;
         if (o_ctrl_state == 2'd1) saw_demod = 1;
      end
      bytes = 1'b0; fcs = 1'b1;
      tick();
      fcs = 1'b0; demod = 1'b0;
      chk("normal_idle", int'(o_ctrl_state), 0);
      chk("normal_saw_demod", int'(saw_demod), 1);
      chk("normal_no_rst", int'(saw_rst), 0);
      chk("normal_abort", int'(o_abort_cnt), 0);
      tick();

      // stall abort
      demod = 1'b1;
      tick();
      chk("stall_demod", int'(o_ctrl_state), 1);
      n = 0;
      while (o_ctrl_state != 2'd2 && n < 200) begin tick(); n++; end
      chk("stall_latency", n, 101);
      demod = 1'b0;
      hc = 0;
      while (o_core_rst && hc < 20) begin hc++; tick(); end
      chk("stall_rst_len", hc, 8);
      chk("stall_cause", int'(o_last_cause), 3);
      chk("stall_tmo_cnt", int'(o_timeout_cnt), 1);
      chk("stall_abort_cnt", int'(o_abort_cnt), 1);
      wait_state(0, 100, "stall_back_idle");

      // TX during DEMOD
      demod = 1'b1;
      repeat (5) tick();
      tx = 1'b1;
      tick();
      chk("tx_reset", int'(o_ctrl_state), 2);
      chk("tx_cause", int'(o_last_cause), 1);
      repeat (49) tick();
      chk("tx_holdoff_held", int'(o_ctrl_state), 3);
      tx = 1'b0; demod = 1'b0;
      hc = 0;
      do begin
         tick();
         if (o_ctrl_state == 2'd3) hc++;
      end while (o_ctrl_state == 2'd3 && hc < 100);
      chk("tx_holdoff_len", hc, 20);
      chk("tx_core_en", int'(o_core_enable), 1);

      // ht_unsupport
      a0 = int'(o_abort_cnt); t0 = int'(o_timeout_cnt);
      demod = 1'b1;
      tick();
      ht = 1'b1;
      tick();
      ht = 1'b0; demod = 1'b0;
      chk("ht_cause", int'(o_last_cause), 2);
      chk("ht_abort", int'(o_abort_cnt), a0 + 1);
      chk("ht_tmo", int'(o_timeout_cnt), t0);
      wait_state(0, 60, "ht_back_idle");

      // fcs on expiry clock
      a0 = int'(o_abort_cnt);
      demod = 1'b1;
      tick();
      repeat (100) tick();
      fcs = 1'b1;
      tick();
      fcs = 1'b0; demod = 1'b0;
      chk("fcs_expiry_idle", int'(o_ctrl_state), 0);
      chk("fcs_expiry_abort", int'(o_abort_cnt), a0);
      tick();

      // progress on expiry clock
      demod = 1'b1;
      tick();
      repeat (100) tick();
      bytes = 1'b1;
      tick();
      bytes = 1'b0; demod = 1'b0;
      chk("prog_expiry_state", int'(o_ctrl_state), 2);
      chk("prog_expiry_cause", int'(o_last_cause), 3);
      wait_state(0, 60, "prog_back_idle");

      // timeout lowered below running timer
      demod = 1'b1;
      tick();
      repeat (50) tick();
      tmo_cfg = 20'd10;
      tick();
      chk("lowered_abort", int'(o_ctrl_state), 2);
      tmo_cfg = 20'd100; demod = 1'b0;
      wait_state(0, 60, "lowered_back_idle");

      // no timeout when disabled
      a0 = int'(o_abort_cnt);
      tmo_cfg = 20'd0; demod = 1'b1;
      repeat (2000) tick();
      chk("tmo0_still_demod", int'(o_ctrl_state), 1);
      tmo_cfg = 20'd100; en = 1'b0;
      repeat (2000) tick();
      chk("en0_still_demod", int'(o_ctrl_state), 1);
      chk("no_timeout_abort", int'(o_abort_cnt), a0);
      en = 1'b1; demod = 1'b0;
      tick();

      // async reset mid-RESET and mid-HOLDOFF
      tx = 1'b1;
      tick();
      tx = 1'b0;
      repeat (3) tick();
      chk("mid_reset_state", int'(o_ctrl_state), 2);
      async_reset_check("arst_reset");
      tx = 1'b1;
      tick();
      tx = 1'b0;
      repeat (12) tick();
      chk("mid_holdoff_state", int'(o_ctrl_state), 3);
      async_reset_check("arst_holdoff");

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            en = 1'($urandom_range(0, 3) != 0);
            tmo_cfg = 20'($urandom_range(0, 40));
            hold_cfg = 16'($urandom_range(0, 20));
         end
         if ($urandom_range(0, 59) == 0) tx = ~tx;
         if ($urandom_range(0, 29) == 0) demod = ~demod;
         bytes = 1'($urandom_range(0, 7) == 0);
         hdr = 1'($urandom_range(0, 39) == 0);
         ht = 1'($urandom_range(0, 149) == 0);
         fcs = 1'($urandom_range(0, 59) == 0);
         tick();
      end
      tx = 1'b0; demod = 1'b0; bytes = 1'b0; hdr = 1'b0; ht = 1'b0; fcs = 1'b0;
      tick();

      // saturation of abort_cnt
      async_reset_check("arst_sat");
      hold_cfg = 16'd0; en = 1'b1;
      for (int k = 0; k < CMAX + 2; k++) begin
         tx = 1'b1;
         tick();
         tx = 1'b0;
         wait_state(0, 30, "sat_back_idle");
      end
      chk("abort_saturated", int'(o_abort_cnt), CMAX);
      chk("sat_cause", int'(o_last_cause), 1);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
